ofdm_cp_serializer: RTL and testbench

//  Downstream stage of ifft_8_point. Captures one 8-sample complex symbol when the IFFT's data_ready pulses.

---
 rtl/ofdm_cp_serializer_pkg.sv | 27 ++
 rtl/ofdm_cp_serializer_if.sv | 33 +++
 rtl/ofdm_round_sat.sv | 31 +++
 rtl/ofdm_cp_serializer.sv | 181 ++++++++++++++++++
 tb/tb_ofdm_cp_serializer.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ofdm_cp_serializer_pkg.sv
// Shared OFDM symbol constants, FSM encoding and beat-to-sample mapping.
// Also used by the future cyclic-prefix remover.
package ofdm_cp_serializer_pkg;

  localparam int OFDM_N        = 8;
  localparam int OFDM_SAMPLE_W = 16;
  localparam int IDX_W         = 3;
  localparam int BEAT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_BODY = 2'd2
  } fsm_state_e;

  // Beat b of a symbol carries sample (b + N - cp) mod N
  function automatic logic [IDX_W-1:0] beat_sample(
    input logic [BEAT_W-1:0] beat,
    input int                cp_len
  );
    int s;
    s = int'(beat) + OFDM_N - cp_len;
    if (s >= OFDM_N) s = s - OFDM_N;
    return IDX_W'(s);
  endfunction

endpackage

// File: rtl/ofdm_cp_serializer_if.sv
// Symbol-in / sample-out stream bundle of the cyclic-prefix serializer.
// master = symbol source + sample sink, slave = serializer.
interface ofdm_cp_serializer_if
  import ofdm_cp_serializer_pkg::*;
#(
  parameter int IN_W  = OFDM_SAMPLE_W,
  parameter int OUT_W = 12
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_i [OFDM_N];
  logic signed [IN_W-1:0]  in_q [OFDM_N];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_i;
  logic signed [OUT_W-1:0] out_q;
  logic                    out_sop;
  logic                    out_eop;

  modport master (
    output in_valid, in_i, in_q, out_ready,
    input  in_ready, out_valid, out_i, out_q,
    input  out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_i, in_q, out_ready,
    output in_ready, out_valid, out_i, out_q,
    output out_sop, out_eop
  );

endinterface

// File: rtl/ofdm_round_sat.sv
// Round half-up, arithmetic right shift and saturate one signed sample.
// The add is one bit wider than the input so it can never wrap.
module ofdm_round_sat #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12,
  parameter int SHIFT = 3
) (
  input  logic signed [IN_W-1:0]  x,
  output logic signed [OUT_W-1:0] y
);

  localparam int TW = IN_W + 1;
  localparam logic signed [TW-1:0] RND  = TW'((2 ** SHIFT) / 2);
  localparam logic signed [TW-1:0] MAXV = TW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [TW-1:0] MINV = TW'(-(2 ** (OUT_W - 1)));

  logic signed [TW-1:0] t;
  logic signed [TW-1:0] s;

  always_comb begin
    t = $signed({x[IN_W-1], x}) + RND;
    s = t >>> SHIFT;
    if (s > MAXV)
      y = MAXV[OUT_W-1:0];
    else if (s < MINV)
      y = MINV[OUT_W-1:0];
    else
      y = s[OUT_W-1:0];
  end

endmodule

// File: rtl/ofdm_cp_serializer.sv
// Double-buffered OFDM symbol serializer: emits cyclic prefix then body,
// one rounded/saturated complex sample per valid/ready beat.
module ofdm_cp_serializer
  import ofdm_cp_serializer_pkg::*;
#(
  parameter int CP_LEN = 2,
  parameter int IN_W   = OFDM_SAMPLE_W,
  parameter int OUT_W  = 12,
  parameter int SHIFT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  ofdm_cp_serializer_if.slave bus,
  output logic               overflow
);

  localparam int N = OFDM_N;
  localparam logic [BEAT_W-1:0] LAST =
    BEAT_W'(N + CP_LEN - 1);
  localparam logic [BEAT_W-1:0] CP_END =
    BEAT_W'((CP_LEN > 0) ? CP_LEN - 1 : 0);
  localparam fsm_state_e FIRST_ST =
    fsm_state_e'((CP_LEN > 0) ? ST_CP : ST_BODY);

  logic signed [IN_W-1:0] buf_i [2][N];
  logic signed [IN_W-1:0] buf_q [2][N];

  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  fsm_state_e        state;
  fsm_state_e        state_n;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_n;

  logic in_ready;
  logic cap;
  logic hs;
  logic issue;
  logic rel;
  logic sel;

  logic [IDX_W-1:0]        idx;
  logic signed [IN_W-1:0]  mux_i;
  logic signed [IN_W-1:0]  mux_q;
  logic signed [OUT_W-1:0] rs_i;
  logic signed [OUT_W-1:0] rs_q;

  logic                    out_valid;
  logic                    out_sop;
  logic                    out_eop;
  logic signed [OUT_W-1:0] out_i;
  logic signed [OUT_W-1:0] out_q;

  assign in_ready      = (count < 2'd2);
  assign cap           = bus.in_valid && in_ready;
  assign hs            = out_valid && bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sop   = out_sop;
  assign bus.out_eop   = out_eop;
  assign bus.out_i     = out_i;
  assign bus.out_q     = out_q;

  // state/beat describe the beat currently held in the output register
  always_comb begin
    state_n = state;
    beat_n  = beat;
    issue   = 1'b0;
    rel     = 1'b0;
    sel     = rd_ptr;
    unique case (state)
      ST_IDLE: begin
        if (count != 2'd0) begin
          issue   = 1'b1;
          beat_n  = '0;
          state_n = FIRST_ST;
        end
      end
      ST_CP: begin
        if (hs) begin
          issue  = 1'b1;
          beat_n = beat + 1'b1;
          if (beat == CP_END) state_n = ST_BODY;
        end
      end
      ST_BODY: begin
        if (hs) begin
          if (beat == LAST) begin
            rel = 1'b1;
            if (count == 2'd2) begin
              issue   = 1'b1;
              sel     = ~rd_ptr;
              beat_n  = '0;
              state_n = FIRST_ST;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            issue  = 1'b1;
            beat_n = beat + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign idx   = beat_sample(beat_n, CP_LEN);
  assign mux_i = buf_i[sel][idx];
  assign mux_q = buf_q[sel][idx];

  ofdm_round_sat #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_rs_i (
    .x(mux_i),
    .y(rs_i)
  );

  ofdm_round_sat #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_rs_q (
    .x(mux_q),
    .y(rs_q)
  );

  always_ff @(posedge clk) begin
    if (cap) begin
      for (int k = 0; k < N; k++) begin
        buf_i[wr_ptr][k] <= bus.in_i[k];
        buf_q[wr_ptr][k] <= bus.in_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
    end else begin
      if (cap) wr_ptr <= ~wr_ptr;
      if (rel) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, cap} - {1'b0, rel};
      if (bus.in_valid && !in_ready) overflow <= 1'b1;
      if (!out_valid || bus.out_ready) begin
        out_valid <= issue;
        if (issue) begin
          out_i   <= rs_i;
          out_q   <= rs_q;
          out_sop <= (beat_n == '0);
          out_eop <= (beat_n == LAST);
        end else begin
          out_sop <= 1'b0;
          out_eop <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofdm_cp_serializer.sv
// Bench for ofdm_cp_serializer: CP_LEN=2 and CP_LEN=0 instances share
// stimulus; a symbol-queue model checks both on every cycle.
module tb_ofdm_cp_serializer;

  typedef struct {
    int i [8];
    int q [8];
  } sym_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst       = 1'b1;
  logic in_valid  = 1'b0;
  logic out_ready = 1'b1;
  bit   tog       = 1'b0;
  logic signed [15:0] in_i [8];
  logic signed [15:0] in_q [8];

  int checks = 0;
  int errors = 0;

  logic              o_valid [2];
  logic              o_rdy   [2];
  logic              o_sop   [2];
  logic              o_eop   [2];
  logic              o_ovf   [2];
  logic signed [11:0] o_i    [2];
  logic signed [11:0] o_q    [2];

  ofdm_cp_serializer_if #(.IN_W(16), .OUT_W(12)) ifa ();
  ofdm_cp_serializer_if #(.IN_W(16), .OUT_W(12)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_i      = in_i;
  assign ifa.in_q      = in_q;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_i      = in_i;
  assign ifb.in_q      = in_q;
  assign ifb.out_ready = out_ready;

  ofdm_cp_serializer #(.CP_LEN(2), .IN_W(16), .OUT_W(12), .SHIFT(3)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .overflow(o_ovf[0])
  );

  ofdm_cp_serializer #(.CP_LEN(0), .IN_W(16), .OUT_W(12), .SHIFT(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .overflow(o_ovf[1])
  );

  assign o_valid[0] = ifa.out_valid;
  assign o_rdy[0]   = ifa.in_ready;
  assign o_sop[0]   = ifa.out_sop;
  assign o_eop[0]   = ifa.out_eop;
  assign o_i[0]     = ifa.out_i;
  assign o_q[0]     = ifa.out_q;
  assign o_valid[1] = ifb.out_valid;
  assign o_rdy[1]   = ifb.in_ready;
  assign o_sop[1]   = ifb.out_sop;
  assign o_eop[1]   = ifb.out_eop;
  assign o_i[1]     = ifb.out_i;
  assign o_q[1]     = ifb.out_q;

  task automatic check(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  function automatic int rs(input int x);
    int y;
    y = (x + 4) >>> 3;
    if (y > 2047) y = 2047;
    if (y < -2048) y = -2048;
    return y;
  endfunction

  function automatic int samp(input int p, input int cp);
    return (p < cp) ? 8 - cp + p : p - cp;
  endfunction

  // Model: queue of accepted symbols, head = symbol on the output
  sym_t symq [2][$];
  int   pos  [2];
  bit   ev   [2];
  bit   eovf [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int cp, len, s, sz;
      bit hs, fin, cap;
      sym_t h;
      cp  = (g == 0) ? 2 : 0;
      len = 8 + cp;
      sz  = symq[g].size();
      check($sformatf("in_ready[%0d]", g), int'(o_rdy[g]), int'(sz < 2));
      check($sformatf("out_valid[%0d]", g), int'(o_valid[g]), int'(ev[g]));
      check($sformatf("overflow[%0d]", g), int'(o_ovf[g]), int'(eovf[g]));
      if (ev[g]) begin
        h = symq[g][0];
        s = samp(pos[g], cp);
        check($sformatf("out_i[%0d] beat %0d", g, pos[g]), int'(o_i[g]), rs(h.i[s]));
        check($sformatf("out_q[%0d] beat %0d", g, pos[g]), int'(o_q[g]), rs(h.q[s]));
        check($sformatf("sop[%0d]", g), int'(o_sop[g]), int'(pos[g] == 0));
        check($sformatf("eop[%0d]", g), int'(o_eop[g]), int'(pos[g] == len - 1));
      end
      if (rst) begin
        symq[g].delete();
        ev[g]   = 1'b0;
        eovf[g] = 1'b0;
        pos[g]  = 0;
      end else begin
        hs  = ev[g] && out_ready;
        fin = hs && (pos[g] == len - 1);
        cap = in_valid && (sz < 2);
        if (in_valid && !cap) eovf[g] = 1'b1;
        if (fin) begin
          void'(symq[g].pop_front());
          ev[g]  = (sz == 2);
          pos[g] = 0;
        end else if (hs) begin
          pos[g]++;
        end else if (!ev[g] && sz > 0) begin
          ev[g]  = 1'b1;
          pos[g] = 0;
        end
        if (cap) begin
          sym_t n;
          for (int k = 0; k < 8; k++) begin
            n.i[k] = int'(in_i[k]);
            n.q[k] = int'(in_q[k]);
          end
          symq[g].push_back(n);
        end
      end
    end
  end

  always @(posedge clk) if (tog) #1 out_ready = ~out_ready;

  int la[$], laq[$], lb[$];
  int fa, fb, ea, eb, runa, runb, maxa, maxb;
  bit sopa, sopb;

  task automatic set_ramp();
    for (int k = 0; k < 8; k++) begin
      in_i[k] = 16'(80 * k);
      in_q[k] = 16'(-80 * k);
    end
  endtask

  task automatic set_rand();
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_i[k] = 16'(int'($urandom_range(0, 60)) - 30);
        in_q[k] = 16'(int'($urandom_range(0, 60)) - 30);
      end else begin
        in_i[k] = 16'($urandom);
        in_q[k] = 16'($urandom);
      end
    end
  endtask

  task automatic strobe(input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rnd) set_rand();
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input int ncyc);
    la.delete(); laq.delete(); lb.delete();
    fa = -1; fb = -1; ea = -1; eb = -1;
    runa = 0; runb = 0; maxa = 0; maxb = 0;
    sopa = 0; sopb = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (o_valid[0]) begin
        runa++;
        if (runa > maxa) maxa = runa;
      end else runa = 0;
      if (o_valid[1]) begin
        runb++;
        if (runb > maxb) maxb = runb;
      end else runb = 0;
      if (o_valid[0] && out_ready) begin
        if (fa < 0) begin fa = c; sopa = o_sop[0]; end
        la.push_back(int'(o_i[0]));
        laq.push_back(int'(o_q[0]));
        if (o_eop[0] && ea < 0) ea = la.size();
      end
      if (o_valid[1] && out_ready) begin
        if (fb < 0) begin fb = c; sopb = o_sop[1]; end
        lb.push_back(int'(o_i[1]));
        if (o_eop[1] && eb < 0) eb = lb.size();
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1 [10];
    int t2 [5];
    t1 = '{60, 70, 0, 10, 20, 30, 40, 50, 60, 70};
    t2 = '{2, -1, 1, 2047, -2048};
    for (int k = 0; k < 8; k++) begin
      in_i[k] = '0;
      in_q[k] = '0;
    end

    check("pin rs(12)", rs(12), 2);
    check("pin rs(-12)", rs(-12), -1);
    check("pin rs(-32768)", rs(-32768), -2048);
    check("pin samp(0,2)", samp(0, 2), 6);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset valid[%0d]", g), int'(o_valid[g]), 0);
      check($sformatf("reset ready[%0d]", g), int'(o_rdy[g]), 1);
      check($sformatf("reset ovf[%0d]", g), int'(o_ovf[g]), 0);
    end

    // ramp
    set_ramp();
    strobe(1, 0);
    collect(14);
    check("t1 latency a", fa, 1);
    check("t1 sop a", int'(sopa), 1);
    check("t1 beats a", la.size(), 10);
    check("t1 eop a", ea, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t1 a_i%0d", i), la[i], t1[i]);
      check($sformatf("t1 a_q%0d", i), laq[i], -t1[i]);
    end
    check("t6 latency b", fb, 1);
    check("t6 sop b", int'(sopb), 1);
    check("t6 beats b", lb.size(), 8);
    check("t6 eop b", eb, 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t6 b_i%0d", i), lb[i], 10 * i);

    // round and saturate
    for (int k = 0; k < 8; k++) begin
      in_i[k] = '0;
      in_q[k] = '0;
    end
    in_i[0] = 16'sd12;
    in_i[1] = -16'sd12;
    in_i[2] = 16'sd11;
    in_i[3] = 16'sd32767;
    in_i[4] = -16'sd32768;
    strobe(1, 0);
    collect(14);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("t2 a body%0d", j), la[j + 2], t2[j]);
      check($sformatf("t2 b body%0d", j), lb[j], t2[j]);
    end

    // back-to-back
    strobe(2, 1);
    check("t3 ready a", int'(o_rdy[0]), 0);
    check("t3 ready b", int'(o_rdy[1]), 0);
    collect(30);
    check("t3 run a", maxa, 20);
    check("t3 run b", maxb, 16);

    // stall and drop
    tog = 1'b1;
    strobe(3, 1);
    check("t4 ovf a", int'(o_ovf[0]), 1);
    check("t4 ovf b", int'(o_ovf[1]), 1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    tog = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (4) @(posedge clk);

    // reset mid-symbol
    set_ramp();
    strobe(1, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t5 valid[%0d]", g), int'(o_valid[g]), 0);
      check($sformatf("t5 ready[%0d]", g), int'(o_rdy[g]), 1);
      check($sformatf("t5 ovf[%0d]", g), int'(o_ovf[g]), 0);
    end
    strobe(1, 0);
    collect(14);
    check("t5 sop a", int'(sopa), 1);
    check("t5 first a", la[0], 60);
    check("t5 sop b", int'(sopb), 1);
    check("t5 first b", lb[0], 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 599) == 0);
      in_valid = ($urandom_range(0, 4) == 0);
      if (in_valid) set_rand();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
